plic_claim_ctrl: RTL and testbench

Memory-mapped configuration and claim/complete controller for the interrupt controller core. It holds per-source priority, enable bits and a priority threshold, and drives those into the core. It drives the single external interrupt line to the CPU and runs the claim/complete handshake, issuing one-cycle `int_claim` pulses back to the core. It sits between the CPU data bus (simple valid/ready request/response) and the core.

---
 rtl/plic_claim_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_plic_claim_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_ctrl.sv
// -----------------------------------------------------------------------------
// plic_claim_ctrl
//
// Bus-facing configuration and claim/complete controller that sits between
// the CPU data bus and the interrupt controller core. It holds per-source
// priority, the enable mask and the priority threshold, and drives them into
// the core. It also drives the external interrupt line to the CPU and runs
// the claim/complete handshake.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   req_*             bus request channel (valid/ready, write, addr, wdata)
//   rsp_*             bus response channel (valid/ready, rdata)
//   core_pending/id   winning pending source reported by the core
//   int_priority      packed per-source priority, source i at [i*PW +: PW]
//   int_enable        per-source enable mask
//   int_claim         one-hot, single-cycle claim pulse to the core
//   ext_irq           registered interrupt request to the CPU
//
// Register map (word aligned, addr[1:0] ignored):
//   0x00 + 4*i  priority[i]     0x40 enable     0x44 threshold
//   0x48        read = claim (ID+1 or 0), write = complete (ID+1)
// -----------------------------------------------------------------------------
module plic_claim_ctrl #(
  parameter int PORTS          = 4,
  parameter int ID_WIDTH       = $clog2(PORTS),
  parameter int PRIORITY_WIDTH = $clog2(PORTS + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [7:0]                        req_addr,
  input  logic [31:0]                       req_wdata,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [31:0]                       rsp_rdata,
  input  logic                              core_pending,
  input  logic [ID_WIDTH-1:0]               core_id,
  output logic [PORTS*PRIORITY_WIDTH-1:0]   int_priority,
  output logic [PORTS-1:0]                  int_enable,
  output logic [PORTS-1:0]                  int_claim,
  output logic                              ext_irq
);

  localparam int PW = PRIORITY_WIDTH;
  localparam int CW = ID_WIDTH + 1;   // width of an ID+1 claim/complete value

  typedef enum logic [0:0] {
    ST_IDLE       = 1'b0,
    ST_IN_SERVICE = 1'b1
  } state_e;

  // Registered state
  logic [PW-1:0]       prio_q [PORTS];
  logic [PW-1:0]       prio_d [PORTS];
  logic [PORTS-1:0]    enable_q, enable_d;
  logic [PW-1:0]       thresh_q, thresh_d;
  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] svc_id_q, svc_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic [PORTS-1:0]    int_claim_q, int_claim_d;
  logic                ext_irq_q, ext_irq_d;

  // Combinational helpers
  logic                req_ready_s;
  logic                accept_s;
  logic [5:0]          word_s;
  logic                is_prio_s, is_enable_s, is_thresh_s, is_claim_s;
  logic                claim_rd_s, complete_s;
  logic [PW-1:0]       core_prio_s;
  logic                core_en_s;
  logic [PORTS-1:0]    claim_onehot_s;
  logic [PW-1:0]       prio_rd_s;
  logic                eligible_s;
  logic [31:0]         rd_data_s;
  logic                unused_s;

  // Only the low field bits of write data and the word part of the address matter.
  assign unused_s = ^{req_addr[1:0], req_wdata};

  assign req_ready_s = !rsp_valid_q || rsp_ready;
  assign accept_s    = req_valid && req_ready_s;
  assign word_s      = req_addr[7:2];
  assign is_prio_s   = (word_s < 6'(PORTS));
  assign is_enable_s = (word_s == 6'd16);
  assign is_thresh_s = (word_s == 6'd17);
  assign is_claim_s  = (word_s == 6'd18);
  assign claim_rd_s  = accept_s && !req_write && is_claim_s;
  assign complete_s  = accept_s && req_write && is_claim_s;

  // Per-source lookups: core's winning source config, its one-hot, and the
  // priority word addressed by the bus. An out-of-range core_id matches no
  // source and therefore reads as disabled with priority 0.
  always_comb begin
    core_prio_s    = {PW{1'b0}};
    core_en_s      = 1'b0;
    claim_onehot_s = {PORTS{1'b0}};
    prio_rd_s      = {PW{1'b0}};
    for (int i = 0; i < PORTS; i++) begin
      claim_onehot_s[i] = (core_id == ID_WIDTH'(i));
      core_prio_s       = core_prio_s | (claim_onehot_s[i] ? prio_q[i] : {PW{1'b0}});
      core_en_s         = core_en_s | (claim_onehot_s[i] & enable_q[i]);
      prio_rd_s         = prio_rd_s | ((word_s == 6'(i)) ? prio_q[i] : {PW{1'b0}});
    end
  end

  // Priority 0 can never exceed an unsigned threshold, so it is never eligible.
  assign eligible_s = core_pending && core_en_s && (core_prio_s > thresh_q);

  // Read data mux; the claim register returns ID+1 only when a claim would be granted.
  always_comb begin
    rd_data_s = 32'd0;
    if (is_prio_s) begin
      rd_data_s = 32'(prio_rd_s);
    end else if (is_enable_s) begin
      rd_data_s = 32'(enable_q);
    end else if (is_thresh_s) begin
      rd_data_s = 32'(thresh_q);
    end else if (is_claim_s) begin
      rd_data_s = ((state_q == ST_IDLE) && eligible_s) ? (32'(core_id) + 32'd1) : 32'd0;
    end else begin
      rd_data_s = 32'd0;
    end
  end

  // Configuration register next-state: field writes truncate to the field width.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      prio_d[i] = (accept_s && req_write && is_prio_s && (word_s == 6'(i)))
                  ? req_wdata[PW-1:0] : prio_q[i];
    end
    enable_d = (accept_s && req_write && is_enable_s) ? req_wdata[PORTS-1:0] : enable_q;
    thresh_d = (accept_s && req_write && is_thresh_s) ? req_wdata[PW-1:0] : thresh_q;
  end

  // Response channel: load on accept, hold until consumed.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = req_write ? 32'd0 : rd_data_s;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Claim/complete state machine; the claim pulse is generated only on the
  // accept cycle, so a stalled response never repeats it.
  always_comb begin
    state_d     = state_q;
    svc_id_d    = svc_id_q;
    int_claim_d = {PORTS{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (claim_rd_s && eligible_s) begin
          state_d     = ST_IN_SERVICE;
          svc_id_d    = core_id;
          int_claim_d = claim_onehot_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IN_SERVICE: begin
        if (complete_s && (req_wdata[ID_WIDTH:0] == (CW'(svc_id_q) + CW'(1)))) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IN_SERVICE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ext_irq_d = (state_q == ST_IDLE) && eligible_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PORTS; i++) begin
        prio_q[i] <= {PW{1'b0}};
      end
      enable_q    <= {PORTS{1'b0}};
      thresh_q    <= {PW{1'b0}};
      state_q     <= ST_IDLE;
      svc_id_q    <= {ID_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      int_claim_q <= {PORTS{1'b0}};
      ext_irq_q   <= 1'b0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        prio_q[i] <= prio_d[i];
      end
      enable_q    <= enable_d;
      thresh_q    <= thresh_d;
      state_q     <= state_d;
      svc_id_q    <= svc_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      int_claim_q <= int_claim_d;
      ext_irq_q   <= ext_irq_d;
    end
  end

  // Pack the priority array onto the core-facing bus.
  always_comb begin
    int_priority = {(PORTS*PW){1'b0}};
    for (int i = 0; i < PORTS; i++) begin
      int_priority[i*PW +: PW] = prio_q[i];
    end
  end

  assign req_ready  = req_ready_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign int_enable = enable_q;
  assign int_claim  = int_claim_q;
  assign ext_irq    = ext_irq_q;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_plic_claim_ctrl
//
// Directed self-checking bench for plic_claim_ctrl with PORTS = 4
// (ID_WIDTH = 2, PRIORITY_WIDTH = 3). Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_plic_claim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        core_pending;
  logic [1:0]  core_id;
  logic [11:0] int_priority;
  logic [3:0]  int_enable;
  logic [3:0]  int_claim;
  logic        ext_irq;

  int checks   = 0;
  int failures = 0;

  plic_claim_ctrl #(.PORTS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .core_pending (core_pending),
    .core_id      (core_id),
    .int_priority (int_priority),
    .int_enable   (int_enable),
    .int_claim    (int_claim),
    .ext_irq      (ext_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus transfer with rsp_ready high; returns data and claim seen at N+1.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [3:0] clm);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    chk("req_ready_at_issue", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    chk("rsp_valid_after_accept", 32'(rsp_valid), 32'd1);
    rd  = rsp_rdata;
    clm = int_claim;
    if (wr) chk("write_rsp_rdata_zero", rsp_rdata, 32'd0);
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic [3:0]  clm;
    xfer(1'b1, addr, wd, rd, clm);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr,
                        input logic [31:0] exp_rd, input logic [3:0] exp_clm);
    logic [31:0] rd;
    logic [3:0]  clm;
    xfer(1'b0, addr, 32'd0, rd, clm);
    chk(tag, rd, exp_rd);
    chk({tag, "_claim"}, 32'(clm), 32'(exp_clm));
  endtask

  initial begin
    int pulses;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = 8'h00;
    req_wdata    = 32'd0;
    rsp_ready    = 1'b1;
    core_pending = 1'b0;
    core_id      = 2'd0;

    // Reset state
    wait_cyc(3);
    rst_n = 1'b1;
    chk("reset_ext_irq", 32'(ext_irq), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_int_claim", 32'(int_claim), 32'd0);
    rd_chk("reset_rd_prio0", 8'h00, 32'd0, 4'b0000);
    rd_chk("reset_rd_enable", 8'h40, 32'd0, 4'b0000);
    rd_chk("reset_rd_thresh", 8'h44, 32'd0, 4'b0000);
    rd_chk("reset_rd_claim", 8'h48, 32'd0, 4'b0000);

    // Configure source 2: priority write truncates to 3 bits (0xFFFFFFFB -> 3)
    wr_reg(8'h08, 32'hFFFF_FFFB);
    wr_reg(8'h40, 32'h0000_0004);
    wr_reg(8'h44, 32'h0000_0001);
    chk("cfg_int_priority", 32'(int_priority), 32'h0000_00C0);
    chk("cfg_int_enable", 32'(int_enable), 32'h0000_0004);
    rd_chk("cfg_rd_prio2_trunc", 8'h08, 32'd3, 4'b0000);
    core_pending = 1'b1;
    core_id      = 2'd2;
    wait_cyc(2);
    chk("irq_asserted", 32'(ext_irq), 32'd1);

    // Unmapped addresses: priority[4] slot and 0x4C
    wr_reg(8'h10, 32'h0000_0007);
    rd_chk("unmapped_rd_0x10", 8'h10, 32'd0, 4'b0000);
    rd_chk("unmapped_rd_0x4c", 8'h4C, 32'd0, 4'b0000);
    chk("unmapped_no_side_effect", 32'(int_priority), 32'h0000_00C0);

    // Claim source 2
    rd_chk("claim_src2", 8'h48, 32'd3, 4'b0100);
    wait_cyc(1);
    chk("claim_pulse_ends", 32'(int_claim), 32'd0);
    chk("claim_irq_drops", 32'(ext_irq), 32'd0);
    rd_chk("claim_nested", 8'h48, 32'd0, 4'b0000);

    // Wrong completion is ignored
    wr_reg(8'h48, 32'd1);
    wait_cyc(2);
    chk("bad_complete_irq_low", 32'(ext_irq), 32'd0);
    rd_chk("bad_complete_still_busy", 8'h48, 32'd0, 4'b0000);

    // Matching completion returns to IDLE; irq reasserts one cycle later
    wr_reg(8'h48, 32'd3);
    chk("complete_irq_n1", 32'(ext_irq), 32'd0);
    wait_cyc(1);
    chk("complete_irq_n2", 32'(ext_irq), 32'd1);

    // Threshold boundary on source 1: priority 2 vs threshold 2
    core_id = 2'd1;
    wr_reg(8'h44, 32'd2);
    wr_reg(8'h04, 32'd2);
    wr_reg(8'h40, 32'h0000_0002);
    wait_cyc(2);
    chk("thr_equal_irq_low", 32'(ext_irq), 32'd0);
    chk("thr_int_priority", 32'(int_priority), 32'h0000_00D0);
    rd_chk("thr_equal_claim", 8'h48, 32'd0, 4'b0000);
    wr_reg(8'h44, 32'd1);
    wait_cyc(2);
    chk("thr_below_irq_high", 32'(ext_irq), 32'd1);

    // Claim with a stalled response
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h48;
    chk("stall_req_ready_issue", 32'(req_ready), 32'd1);
    @(posedge clk);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, 32'd2);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      if (int_claim == 4'b0010) pulses++;
      else if (int_claim != 4'b0000) pulses += 10;
    end
    chk("stall_claim_pulses", 32'(pulses), 32'd1);

    // Reset mid-service with pending response
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_int_claim", 32'(int_claim), 32'd0);
    chk("midrst_ext_irq", 32'(ext_irq), 32'd0);
    chk("midrst_int_priority", 32'(int_priority), 32'd0);
    chk("midrst_int_enable", 32'(int_enable), 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    rd_chk("midrst_rd_prio1", 8'h04, 32'd0, 4'b0000);
    rd_chk("midrst_rd_enable", 8'h40, 32'd0, 4'b0000);
    rd_chk("midrst_rd_thresh", 8'h44, 32'd0, 4'b0000);
    // State must be IDLE: a freshly eligible source raises irq and can be claimed
    wr_reg(8'h04, 32'd2);
    wr_reg(8'h40, 32'h0000_0002);
    wait_cyc(2);
    chk("midrst_idle_irq", 32'(ext_irq), 32'd1);
    rd_chk("midrst_claim_src1", 8'h48, 32'd2, 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
